// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-access stage: opcodes, FSM encoding,
// datapath width and small opcode classification helpers.
package mem_access_ctrl_pkg;

  localparam int WORD_W = 32;

  // Execute-stage opcodes seen by this stage.
  localparam logic [7:0] OP_LB   = 8'h90;
  localparam logic [7:0] OP_LW   = 8'h92;
  localparam logic [7:0] OP_SB   = 8'h98;
  localparam logic [7:0] OP_SW   = 8'h9A;
  localparam logic [7:0] OP_MULT = 8'h14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SW);
  endfunction

  // Word accesses are the only ones that can be misaligned.
  function automatic logic is_word(input logic [7:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge bus between the memory-access stage and data memory.
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic              dm_req_o;
  logic              dm_we_o;
  logic [3:0]        dm_be_o;
  logic [WORD_W-1:0] dm_addr_o;
  logic [WORD_W-1:0] dm_wdata_o;
  logic [WORD_W-1:0] dm_rdata_i;
  logic              dm_ack_i;

  // Controller side.
  modport master (
    output dm_req_o, dm_we_o, dm_be_o, dm_addr_o, dm_wdata_o,
    input  dm_rdata_i, dm_ack_i
  );

  // Memory side.
  modport slave (
    input  dm_req_o, dm_we_o, dm_be_o, dm_addr_o, dm_wdata_o,
    output dm_rdata_i, dm_ack_i
  );

endinterface

// File: rtl/mem_load_align.sv
// Byte lane handling: byte enables and data replication for stores,
// byte select and sign extension for loads (little-endian).
module mem_load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [7:0]        aluop_i,
  input  logic [1:0]        offset_i,
  input  logic [WORD_W-1:0] din_i,
  input  logic [WORD_W-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [WORD_W-1:0] wdata_o,
  output logic [WORD_W-1:0] ldata_o
);

  logic [7:0] byte_sel;
  logic       is_byte;

  // Select the addressed byte and shape data for word or byte access.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    is_byte = (aluop_i == OP_LB) || (aluop_i == OP_SB);
    be_o    = 4'b1111;
    wdata_o = din_i;
    ldata_o = rdata_i;
    if (is_byte) begin
      be_o    = 4'b0001 << offset_i;
      wdata_o = {4{din_i[7:0]}};
      ldata_o = {{24{byte_sel[7]}}, byte_sel};
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access pipeline stage: issues LB/LW/SB/SW to a variable-latency
// data memory over a req/ack bus, stalls upstream while an access is in
// flight, aborts on timeout and flags misaligned word accesses.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic              cpu_clk_50M,
  input  logic              rst_n,
  input  logic [7:0]        mem_aluop_i,
  input  logic [4:0]        mem_wa_i,
  input  logic [WORD_W-1:0] mem_wd_i,
  input  logic              mem_wreg_i,
  input  logic              mem_mreg_i,
  input  logic [WORD_W-1:0] mem_din_i,
  input  logic              mem_whilo_i,
  input  logic [63:0]       mem_hilo_i,
  mem_access_ctrl_if.master dm,
  output logic              stall_req_o,
  output logic [4:0]        mem_wa_o,
  output logic              mem_wreg_o,
  output logic [WORD_W-1:0] mem_dreg_o,
  output logic              mem_whilo_o,
  output logic [63:0]       mem_hilo_o,
  output logic              mem_err_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] ldbuf_q, ldbuf_d;
  logic              tout_q, tout_d;
  // Request fields latched on issue so the bus is stable during WAIT.
  logic              rq_we_q, rq_we_d;
  logic [3:0]        rq_be_q, rq_be_d;
  logic [WORD_W-1:0] rq_addr_q, rq_addr_d;
  logic [WORD_W-1:0] rq_wdata_q, rq_wdata_d;

  logic              mem_op, misaligned;
  logic [3:0]        al_be;
  logic [WORD_W-1:0] al_wdata, al_ldata;

  assign mem_op     = is_load(mem_aluop_i) || is_store(mem_aluop_i);
  assign misaligned = is_word(mem_aluop_i) && (mem_wd_i[1:0] != 2'b00);

  mem_load_align u_align (
    .aluop_i  (mem_aluop_i),
    .offset_i (mem_wd_i[1:0]),
    .din_i    (mem_din_i),
    .rdata_i  (ldbuf_q),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .ldata_o  (al_ldata)
  );

  // State and datapath registers.
  always_ff @(posedge cpu_clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ldbuf_q    <= '0;
      tout_q     <= 1'b0;
      rq_we_q    <= 1'b0;
      rq_be_q    <= '0;
      rq_addr_q  <= '0;
      rq_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ldbuf_q    <= ldbuf_d;
      tout_q     <= tout_d;
      rq_we_q    <= rq_we_d;
      rq_be_q    <= rq_be_d;
      rq_addr_q  <= rq_addr_d;
      rq_wdata_q <= rq_wdata_d;
    end
  end

  // Next-state logic, bus drive and write-back outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ldbuf_d       = ldbuf_q;
    tout_d        = 1'b0;
    rq_we_d       = rq_we_q;
    rq_be_d       = rq_be_q;
    rq_addr_d     = rq_addr_q;
    rq_wdata_d    = rq_wdata_q;
    dm.dm_req_o   = 1'b0;
    dm.dm_we_o    = 1'b0;
    dm.dm_be_o    = '0;
    dm.dm_addr_o  = '0;
    dm.dm_wdata_o = '0;
    stall_req_o   = 1'b0;
    mem_wa_o      = mem_wa_i;
    mem_wreg_o    = mem_wreg_i;
    mem_dreg_o    = mem_wd_i;
    mem_whilo_o   = mem_whilo_i;
    mem_hilo_o    = mem_hilo_i;
    mem_err_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_op && misaligned) begin
          mem_err_o  = 1'b1;
          mem_wreg_o = 1'b0;
        end else if (mem_op) begin
          dm.dm_req_o   = 1'b1;
          dm.dm_we_o    = is_store(mem_aluop_i);
          dm.dm_be_o    = al_be;
          dm.dm_addr_o  = {mem_wd_i[WORD_W-1:2], 2'b00};
          dm.dm_wdata_o = al_wdata;
          stall_req_o   = 1'b1;
          mem_wreg_o    = 1'b0;
          rq_we_d       = is_store(mem_aluop_i);
          rq_be_d       = al_be;
          rq_addr_d     = {mem_wd_i[WORD_W-1:2], 2'b00};
          rq_wdata_d    = al_wdata;
          if (dm.dm_ack_i) begin
            ldbuf_d = dm.dm_rdata_i;
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        dm.dm_req_o   = 1'b1;
        dm.dm_we_o    = rq_we_q;
        dm.dm_be_o    = rq_be_q;
        dm.dm_addr_o  = rq_addr_q;
        dm.dm_wdata_o = rq_wdata_q;
        stall_req_o   = 1'b1;
        mem_wreg_o    = 1'b0;
        cnt_d         = cnt_q + 1'b1;
        if (dm.dm_ack_i) begin
          ldbuf_d = dm.dm_rdata_i;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          tout_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (mem_mreg_i) begin
          mem_dreg_o = al_ldata;
        end
        if (tout_q) begin
          mem_wreg_o = 1'b0;
          mem_err_o  = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Reset forces every output low immediately, not at the next edge.
    if (!rst_n) begin
      dm.dm_req_o   = 1'b0;
      dm.dm_we_o    = 1'b0;
      dm.dm_be_o    = '0;
      dm.dm_addr_o  = '0;
      dm.dm_wdata_o = '0;
      stall_req_o   = 1'b0;
      mem_wa_o      = '0;
      mem_wreg_o    = 1'b0;
      mem_dreg_o    = '0;
      mem_whilo_o   = 1'b0;
      mem_hilo_o    = '0;
      mem_err_o     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset
// sequences and randomized operations against a transaction-level model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  aluop;
  logic [4:0]  wa;
  logic [31:0] wd, din;
  logic        wreg, mreg, whilo;
  logic [63:0] hilo;
  logic        stall, wreg_o, whilo_o, err_o;
  logic [4:0]  wa_o;
  logic [31:0] dreg_o;
  logic [63:0] hilo_o;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
    .cpu_clk_50M (clk),
    .rst_n       (rst_n),
    .mem_aluop_i (aluop),
    .mem_wa_i    (wa),
    .mem_wd_i    (wd),
    .mem_wreg_i  (wreg),
    .mem_mreg_i  (mreg),
    .mem_din_i   (din),
    .mem_whilo_i (whilo),
    .mem_hilo_i  (hilo),
    .dm          (bus),
    .stall_req_o (stall),
    .mem_wa_o    (wa_o),
    .mem_wreg_o  (wreg_o),
    .mem_dreg_o  (dreg_o),
    .mem_whilo_o (whilo_o),
    .mem_hilo_o  (hilo_o),
    .mem_err_o   (err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] din;
    logic        wreg;
    logic        whilo;
    logic [63:0] hilo;
    logic [31:0] rdata;
    int          lat;      // cycle index of ack (0 = request cycle), -1 = never
    int          x_stall;
    logic        x_req;
    logic        x_we;
    logic [3:0]  x_be;
    logic        chk_be;
    logic [31:0] x_wdata;
    logic        chk_wd;
    logic [31:0] x_dreg;
    logic        chk_dreg;
    logic        x_wreg;
    logic        x_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: what the stage should do for one operation.
  function automatic vec_t make_vec(input logic [7:0] op, input logic [31:0] addr,
                                    input logic [31:0] d, input logic wr,
                                    input logic [31:0] rdata, input int lat);
    vec_t v;
    logic ld, st, mis, acc, tmo;
    logic [7:0] b;
    ld  = (op == OP_LB) || (op == OP_LW);
    st  = (op == OP_SB) || (op == OP_SW);
    mis = ((op == OP_LW) || (op == OP_SW)) && (addr % 4 != 0);
    acc = (ld || st) && !mis;
    tmo = acc && (lat < 0);
    b   = 8'((rdata >> (8 * (addr % 4))) & 32'hFF);
    v.op = op; v.addr = addr; v.din = d; v.wreg = wr;
    v.whilo = 1'b0; v.hilo = '0; v.rdata = rdata; v.lat = lat;
    v.x_stall  = !acc ? 0 : (tmo ? TO : lat + 1);
    v.x_req    = acc;
    v.x_we     = acc && st;
    v.x_be     = (op == OP_SW) ? 4'b1111 : 4'(1 << (addr % 4));
    v.chk_be   = acc && st;
    v.x_wdata  = (op == OP_SW) ? d : {4{d[7:0]}};
    v.chk_wd   = acc && st;
    v.x_dreg   = (op == OP_LW) ? rdata : (op == OP_LB) ? {{24{b[7]}}, b} : addr;
    v.chk_dreg = !mis && !tmo;
    v.x_wreg   = wr && !mis && !tmo;
    v.x_err    = mis || tmo;
    return v;
  endfunction

  // Apply one operation at a negedge, play the memory, check every cycle.
  task automatic run_op(input vec_t v, input string tag);
    logic [31:0] a0;
    logic [4:0]  wa_v;
    int          stall_n, c;
    bit          bad, done;
    @(negedge clk);
    wa_v  = 5'($urandom);
    aluop = v.op; wa = wa_v; wd = v.addr; din = v.din; wreg = v.wreg;
    mreg  = (v.op == OP_LB) || (v.op == OP_LW);
    whilo = v.whilo; hilo = v.hilo;
    stall_n = 0; bad = 0; c = 0; done = 0; a0 = '0;
    while (!done) begin
      bus.dm_ack_i   = (c == v.lat);
      bus.dm_rdata_i = (c == v.lat) ? v.rdata : $urandom;
      #1;
      if (c == 0) begin
        check({tag, ".req"}, bus.dm_req_o, v.x_req);
        if (v.x_req) begin
          check({tag, ".addr"}, bus.dm_addr_o, {v.addr[31:2], 2'b00});
          check({tag, ".we"}, bus.dm_we_o, v.x_we);
          if (v.chk_be) check({tag, ".be"}, bus.dm_be_o, v.x_be);
          if (v.chk_wd) check({tag, ".wdata"}, bus.dm_wdata_o, v.x_wdata);
        end
        a0 = bus.dm_addr_o;
      end
      if (stall && c < 40) begin
        stall_n++;
        if (!bus.dm_req_o || bus.dm_addr_o !== a0 || hilo_o !== v.hilo || whilo_o !== v.whilo)
          bad = 1;
        c++;
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    check({tag, ".stall"}, stall_n, v.x_stall);
    check({tag, ".hold"}, bad, 1'b0);
    check({tag, ".req_end"}, bus.dm_req_o, 1'b0);
    check({tag, ".wreg"}, wreg_o, v.x_wreg);
    check({tag, ".err"}, err_o, v.x_err);
    if (v.chk_dreg) check({tag, ".dreg"}, dreg_o, v.x_dreg);
    check({tag, ".wa"}, wa_o, wa_v);
    check({tag, ".hilo"}, {whilo_o, hilo_o}, {v.whilo, v.hilo});
  endtask

  vec_t tbl [10];

  initial begin
    // Directed vectors with hand-derived expectations:
    //      op       addr          din           wr    whilo hilo                  rdata         lat stall req  we    be       cb    wdata         cw    dreg          cd    wreg  err
    tbl[0] = '{OP_LW,   32'h100,  32'h0,        1'b1, 1'b0, 64'h0,                32'hDEADBEEF,  0,  1, 1'b1, 1'b0, 4'b1111, 1'b1, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{OP_LB,   32'h103,  32'h0,        1'b1, 1'b0, 64'h0,                32'h80112233,  3,  4, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{OP_SB,   32'h2,    32'hA5,       1'b0, 1'b0, 64'h0,                32'h0,         1,  2, 1'b1, 1'b1, 4'b0100, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h2,        1'b0, 1'b0, 1'b0};
    tbl[3] = '{OP_LW,   32'h6,    32'h0,        1'b1, 1'b0, 64'h0,                32'h11111111,  0,  0, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
    tbl[4] = '{OP_LW,   32'h40,   32'h0,        1'b1, 1'b0, 64'h0,                32'h0,        -1, 16, 1'b1, 1'b0, 4'b1111, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
    tbl[5] = '{OP_MULT, 32'h1234, 32'h0,        1'b1, 1'b1, 64'h1_00000002,       32'h0,         0,  0, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h1234,     1'b1, 1'b1, 1'b0};
    tbl[6] = '{OP_SW,   32'h200,  32'hCAFEF00D, 1'b0, 1'b1, 64'h0123456789ABCDEF, 32'h0,         2,  3, 1'b1, 1'b1, 4'b1111, 1'b1, 32'hCAFEF00D, 1'b1, 32'h200,      1'b1, 1'b0, 1'b0};
    tbl[7] = '{OP_SW,   32'h201,  32'h12345678, 1'b0, 1'b0, 64'h0,                32'h0,         0,  0, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
    tbl[8] = '{OP_LB,   32'h101,  32'h0,        1'b1, 1'b0, 64'h0,                32'h12347F00,  0,  1, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0000007F, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{OP_LW,   32'h104,  32'h0,        1'b1, 1'b0, 64'h0,                32'h5A5A0001, 15, 16, 1'b1, 1'b0, 4'b1111, 1'b1, 32'h0,        1'b0, 32'h5A5A0001, 1'b1, 1'b1, 1'b0};

    // Reset holds every output low even with live inputs.
    rst_n = 1'b0;
    aluop = OP_MULT; wa = 5'd7; wd = 32'h1234_5678; din = 32'h0; wreg = 1'b1; mreg = 1'b0;
    whilo = 1'b1; hilo = 64'hFFFF_0000_FFFF_0000;
    bus.dm_ack_i = 1'b1; bus.dm_rdata_i = 32'h0;
    #3;
    check("reset.req", bus.dm_req_o, 1'b0);
    check("reset.stall", stall, 1'b0);
    check("reset.wb", {wa_o, wreg_o, dreg_o, err_o}, '0);
    check("reset.hilo", {whilo_o, hilo_o}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dm_ack_i = 1'b0;

    for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("v%0d", i));

    // Reset asserted in the middle of a WAIT.
    @(negedge clk);
    aluop = OP_LW; wd = 32'h300; mreg = 1'b1; wreg = 1'b1; whilo = 1'b1;
    hilo = 64'hA5A5_5A5A_0F0F_F0F0; bus.dm_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midrst.req_before", bus.dm_req_o, 1'b1);
    check("midrst.stall_before", stall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.req", bus.dm_req_o, 1'b0);
    check("midrst.stall", stall, 1'b0);
    check("midrst.addr", bus.dm_addr_o, 32'h0);
    check("midrst.hilo", {whilo_o, hilo_o}, '0);
    check("midrst.dreg", dreg_o, 32'h0);
    // Late ack after reset, with no memory op pending, must be ignored.
    @(negedge clk);
    rst_n = 1'b1; aluop = 8'h00; mreg = 1'b0; bus.dm_ack_i = 1'b1;
    #1;
    check("lateack.req", bus.dm_req_o, 1'b0);
    check("lateack.stall", stall, 1'b0);
    @(negedge clk);
    #1;
    check("lateack.stall2", stall, 1'b0);
    run_op(make_vec(OP_LW, 32'h300, 32'h0, 1'b1, 32'h600DF00D, 0), "recover");

    // Randomized operations against the model.
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  op;
      logic [31:0] addr;
      int          lat;
      vec_t        v;
      case ($urandom_range(0, 5))
        0:       op = OP_LB;
        1:       op = OP_LW;
        2:       op = OP_SB;
        3:       op = OP_SW;
        4:       op = OP_MULT;
        default: op = 8'($urandom_range(0, 8'h2F));
      endcase
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      lat = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 5);
      v = make_vec(op, addr, $urandom,
                   ((op == OP_LB) || (op == OP_LW)) ? 1'b1 :
                   ((op == OP_SB) || (op == OP_SW)) ? 1'b0 : 1'($urandom),
                   $urandom, lat);
      v.whilo = 1'($urandom);
      v.hilo  = {$urandom, $urandom};
      run_op(v, $sformatf("r%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory-access stage placed directly downstream of the execute stage, after the EXE/MEM pipeline register. It takes the execute results (aluop, write address, ALU result used as effective address, store data, HI/LO info) and runs a req/ack handshake to a variable-latency data memory for LB/LW/SB/SW. While an access is outstanding it stalls the pipeline. It then aligns and extends load data and presents write-back results and HI/LO forwarding to the MEM/WB register and back to execute.

Parameters:
TIMEOUT_CYC, 16, max cycles waiting for dm_ack before the access is aborted
CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYC

Ports:
cpu_clk_50M  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
mem_aluop_i  in  8  op code: 8'h90 LB, 8'h92 LW, 8'h98 SB, 8'h9A SW; others are non-memory
mem_wa_i  in  5  destination register
mem_wd_i  in  32  ALU result; effective address for memory ops
mem_wreg_i  in  1  register write enable
mem_mreg_i  in  1  result comes from memory
mem_din_i  in  32  store data
mem_whilo_i  in  1  HI/LO write enable
mem_hilo_i  in  64  HI/LO value
dm_req_o  out  1  memory request
dm_we_o  out  1  1=store, 0=load
dm_be_o  out  4  byte enables
dm_addr_o  out  32  word address {addr[31:2],2'b00}
dm_wdata_o  out  32  store data
dm_rdata_i  in  32  load data, valid with dm_ack_i
dm_ack_i  in  1  access complete
stall_req_o  out  1  hold all upstream stages
mem_wa_o  out  5  to MEM/WB
mem_wreg_o  out  1  to MEM/WB
mem_dreg_o  out  32  write-back data
mem_whilo_o  out  1  to MEM/WB and execute forwarding (mem_2exe_whilo)
mem_hilo_o  out  64  to MEM/WB and execute forwarding (mem_2exe_hilo)
mem_err_o  out  1  single-cycle pulse on misalignment or timeout

Behaviour:
- FSM states IDLE, WAIT, DONE. Reset puts the FSM in IDLE, clears the counter and load buffer, and drives every output to 0.
- Non-memory op in IDLE: all outputs are combinational pass-throughs. mem_dreg_o=mem_wd_i. stall_req_o=0. No request is issued.
- Aligned memory op in IDLE:
  - dm_req_o=1 and stall_req_o=1 in the same cycle, with dm_addr/we/be/wdata driven from the inputs.
  - If dm_ack_i=1 at the edge: go to DONE.
  - Otherwise go to WAIT and start the counter.
- WAIT:
  - dm_req_o and all dm_* signals stay stable. stall_req_o=1.
  - The counter increments every cycle.
  - ack: capture dm_rdata_i into the load buffer and go to DONE.
  - Counter reaching TIMEOUT_CYC-1 without ack: abort. Drop dm_req_o, set the timeout flag, go to DONE.
- DONE:
  - dm_req_o=0, stall_req_o=0. Outputs come from the current inputs (held by the stall) plus the load buffer.
  - After timeout: mem_wreg_o=0 and mem_err_o=1 for this cycle.
  - Next state is always IDLE. A back-to-back memory op re-requests in its own IDLE cycle.
- Minimum memory-op latency is 2 cycles (request cycle with ack, then DONE). Each extra wait cycle adds 1.
- Store encoding:
  - SW: be=4'b1111, wdata=din.
  - SB: be=4'b0001<<addr[1:0], wdata={4{din[7:0]}}.
- Load data:
  - Little-endian.
  - LW: dreg=word.
  - LB: byte addr[1:0], sign-extended to 32 bits.
- Misaligned op (LW/SW with addr[1:0]!=0):
  - No request, no stall.
  - mem_err_o=1 for that cycle.
  - mem_wreg_o=0 (LW).
  - The store is dropped.
- mem_whilo_o and mem_hilo_o always pass through combinationally, including during a stall.
- rst_n asserted mid-access: FSM returns to IDLE immediately and dm_req_o drops asynchronously. Any late dm_ack_i is ignored in IDLE unless a new request is active.
- dm_ack_i while no request is active: ignored.

Decomposition:
- Shared package holds:
  - aluop constants (LB/LW/SB/SW, plus existing codes such as 8'h14 MULT)
  - the FSM state encoding
  - the word-width constant
- One natural sub-module: mem_load_align (combinational byte select and sign extension for loads, byte-enable and data replication for stores).

Test Plan:
1. LW at addr 0x100, ack on the request cycle, rdata=0xDEADBEEF -> stall for 1 cycle; DONE gives mem_dreg_o=0xDEADBEEF, mem_wreg_o=1, be=4'b1111.
2. LB at addr 0x103, ack after 3 wait cycles, rdata=0x80112233 -> stall for 4 cycles; mem_dreg_o=0xFFFFFF80; dm_addr_o=0x100 held stable throughout.
3. SB at addr 0x0002, din=0x000000A5 -> dm_we_o=1, be=4'b0100, wdata=0xA5A5A5A5; mem_wreg_o=0.
4. LW at addr 0x0006 -> no dm_req_o, no stall, mem_err_o pulses 1 cycle, mem_wreg_o=0.
5. LW with no ack -> stall for exactly TIMEOUT_CYC cycles, then mem_err_o=1 and mem_wreg_o=0. Next IDLE cycle stall_req_o=0.
6. Non-memory MULT with whilo=1, hilo=0x1_00000002 -> passes through combinationally, no stall. Also: rst_n low during WAIT drops dm_req_o and all outputs asynchronously.
